// File: rtl/paint_sequencer_if.sv
// Descriptor push bus into the paint sequencer FIFO.
// The source drives valid and fields; the sequencer returns ready.
interface paint_sequencer_if #(
  parameter int CW = 12
);
  logic          desc_valid;
  logic          desc_ready;
  logic [CW-1:0] desc_sprite_x;
  logic [CW-1:0] desc_sprite_y;
  logic [CW-1:0] desc_frame_x;
  logic [CW-1:0] desc_frame_y;
  logic [CW-1:0] desc_width;
  logic [CW-1:0] desc_height;
  logic          desc_last;

  modport master (
    output desc_valid,
    output desc_sprite_x,
    output desc_sprite_y,
    output desc_frame_x,
    output desc_frame_y,
    output desc_width,
    output desc_height,
    output desc_last,
    input  desc_ready
  );

  modport slave (
    input  desc_valid,
    input  desc_sprite_x,
    input  desc_sprite_y,
    input  desc_frame_x,
    input  desc_frame_y,
    input  desc_width,
    input  desc_height,
    input  desc_last,
    output desc_ready
  );
endinterface

// File: rtl/paint_sequencer.sv
// Element painter front end: descriptor FIFO, optional frame clear
// sweep, and one-at-a-time hand-off of descriptors to the painter.
module paint_sequencer #(
  parameter int COOR_WIDTH   = 12,
  parameter int FIFO_DEPTH   = 16,
  parameter int FRAME_WIDTH  = 1280,
  parameter int FRAME_HEIGHT = 300,
  parameter bit CLEAR_EN     = 1'b1
) (
  input  logic                  clk_33m,
  input  logic                  rst,
  input  logic                  frame_start,
  paint_sequencer_if.slave      desc,
  output logic                  paint_start,
  output logic [COOR_WIDTH-1:0] paint_sprite_x,
  output logic [COOR_WIDTH-1:0] paint_sprite_y,
  output logic [COOR_WIDTH-1:0] paint_frame_x,
  output logic [COOR_WIDTH-1:0] paint_frame_y,
  output logic [COOR_WIDTH-1:0] paint_width,
  output logic [COOR_WIDTH-1:0] paint_height,
  input  logic                  paint_finished,
  output logic                  clr_active,
  output logic [COOR_WIDTH-1:0] clr_x,
  output logic [COOR_WIDTH-1:0] clr_y,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [COOR_WIDTH-1:0] C_ONE = COOR_WIDTH'(1);
  localparam logic [COOR_WIDTH-1:0] X_LAST = COOR_WIDTH'(FRAME_WIDTH-1);
  localparam logic [COOR_WIDTH-1:0] Y_LAST = COOR_WIDTH'(FRAME_HEIGHT-1);

  typedef struct packed {
    logic [COOR_WIDTH-1:0] sx;
    logic [COOR_WIDTH-1:0] sy;
    logic [COOR_WIDTH-1:0] fx;
    logic [COOR_WIDTH-1:0] fy;
    logic [COOR_WIDTH-1:0] w;
    logic [COOR_WIDTH-1:0] h;
    logic                  last;
  } desc_t;

  typedef enum logic [2:0] {
    IDLE, CLEAR, FETCH, START, SETTLE, PAINT, DONE
  } state_t;

  state_t        state;
  desc_t         mem [FIFO_DEPTH];
  desc_t         wr_d;
  desc_t         rd_d;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          cur_last;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign desc.desc_ready = !full;
  assign push  = desc.desc_valid && !full;
  assign pop   = (state == FETCH) && !empty;
  assign rd_d  = mem[rd_ptr];

  assign wr_d = '{
    sx:   desc.desc_sprite_x,
    sy:   desc.desc_sprite_y,
    fx:   desc.desc_frame_x,
    fy:   desc.desc_frame_y,
    w:    desc.desc_width,
    h:    desc.desc_height,
    last: desc.desc_last
  };

  // Storage has no reset; flushing is done by the pointers.
  always_ff @(posedge clk_33m) begin
    if (push) mem[wr_ptr] <= wr_d;
  end

  always_ff @(posedge clk_33m) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
    end
  end

  always_ff @(posedge clk_33m) begin
    if (rst) begin
      state          <= IDLE;
      paint_start    <= 1'b1;
      paint_sprite_x <= '0;
      paint_sprite_y <= '0;
      paint_frame_x  <= '0;
      paint_frame_y  <= '0;
      paint_width    <= '0;
      paint_height   <= '0;
      cur_last       <= 1'b0;
      clr_active     <= 1'b0;
      clr_x          <= '0;
      clr_y          <= '0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (frame_start) begin
            busy <= 1'b1;
            if (CLEAR_EN) begin
              state      <= CLEAR;
              clr_active <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end
        end
        CLEAR: begin
          if (clr_x == X_LAST) begin
            clr_x <= '0;
            if (clr_y == Y_LAST) begin
              clr_y      <= '0;
              clr_active <= 1'b0;
              state      <= FETCH;
            end else begin
              clr_y <= clr_y + C_ONE;
            end
          end else begin
            clr_x <= clr_x + C_ONE;
          end
        end
        FETCH: begin
          if (!empty) begin
            paint_sprite_x <= rd_d.sx;
            paint_sprite_y <= rd_d.sy;
            paint_frame_x  <= rd_d.fx;
            paint_frame_y  <= rd_d.fy;
            paint_width    <= rd_d.w;
            paint_height   <= rd_d.h;
            cur_last       <= rd_d.last;
            // Empty elements never reach the painter.
            if (rd_d.w == '0 || rd_d.h == '0) begin
              if (rd_d.last) begin
                state      <= DONE;
                frame_done <= 1'b1;
              end
            end else begin
              state <= START;
            end
          end
        end
        START: begin
          state       <= SETTLE;
          paint_start <= 1'b0;
        end
        SETTLE: begin
          state <= PAINT;
        end
        PAINT: begin
          if (paint_finished) begin
            paint_start <= 1'b1;
            if (cur_last) begin
              state      <= DONE;
              frame_done <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_paint_sequencer.sv
// Randomized bench for paint_sequencer: queue-based descriptor model,
// responsive painter stand-in and event-level frame checks.
module tb_paint_sequencer;
  localparam int CW = 12;
  localparam int FW = 8;
  localparam int FH = 3;

  typedef struct packed {
    logic [CW-1:0] sx;
    logic [CW-1:0] sy;
    logic [CW-1:0] fx;
    logic [CW-1:0] fy;
    logic [CW-1:0] w;
    logic [CW-1:0] h;
    logic          last;
  } desc_t;

  logic          clk_33m = 1'b0;
  logic          rst = 1'b1;
  logic          frame_start = 1'b0;
  logic          paint_finished = 1'b1;
  logic          paint_start;
  logic          clr_active;
  logic          busy;
  logic          frame_done;
  logic [CW-1:0] paint_sprite_x;
  logic [CW-1:0] paint_sprite_y;
  logic [CW-1:0] paint_frame_x;
  logic [CW-1:0] paint_frame_y;
  logic [CW-1:0] paint_width;
  logic [CW-1:0] paint_height;
  logic [CW-1:0] clr_x;
  logic [CW-1:0] clr_y;

  int    vecs = 0;
  int    errs = 0;
  int    cyc = 0;
  int    lat = 0;
  int    low_cnt = 0;
  int    fin_rise_cyc = -100;
  bit    hang = 1'b0;
  desc_t model_q[$];

  paint_sequencer_if #(.CW(CW)) d();

  paint_sequencer #(
    .COOR_WIDTH  (CW),
    .FIFO_DEPTH  (16),
    .FRAME_WIDTH (FW),
    .FRAME_HEIGHT(FH),
    .CLEAR_EN    (1'b1)
  ) dut (
    .clk_33m       (clk_33m),
    .rst           (rst),
    .frame_start   (frame_start),
    .desc          (d.slave),
    .paint_start   (paint_start),
    .paint_sprite_x(paint_sprite_x),
    .paint_sprite_y(paint_sprite_y),
    .paint_frame_x (paint_frame_x),
    .paint_frame_y (paint_frame_y),
    .paint_width   (paint_width),
    .paint_height  (paint_height),
    .paint_finished(paint_finished),
    .clr_active    (clr_active),
    .clr_x         (clr_x),
    .clr_y         (clr_y),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  always #15 clk_33m = ~clk_33m;

  always @(posedge clk_33m) cyc <= cyc + 1;

  // Painter stand-in: flag stays stale-high for one cycle after release.
  initial begin
    forever begin
      @(posedge clk_33m);
      #1;
      if (paint_start) begin
        low_cnt = 0;
        paint_finished = 1'b1;
      end else begin
        low_cnt++;
        if (low_cnt == 1)
          lat = hang ? 100000 : int'($urandom_range(0, 6));
        else if (low_cnt == 2 + lat)
          fin_rise_cyc = cyc;
        paint_finished = (low_cnt == 1) || (low_cnt >= 2 + lat);
      end
    end
  end

  initial begin
    #(30 * 60000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(string tag, logic [95:0] got, logic [95:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_33m);
    #1;
  endtask

  function automatic desc_t rdesc(bit last, bit zero);
    desc_t x;
    x.sx   = CW'($urandom);
    x.sy   = CW'($urandom);
    x.fx   = CW'($urandom);
    x.fy   = CW'($urandom);
    x.w    = CW'($urandom_range(1, 64));
    x.h    = CW'($urandom_range(1, 64));
    x.last = last;
    if (zero) begin
      if ($urandom_range(0, 1) == 1) x.w = '0;
      else x.h = '0;
    end
    return x;
  endfunction

  function automatic desc_t cur_fields();
    desc_t x;
    x = '{paint_sprite_x, paint_sprite_y, paint_frame_x,
          paint_frame_y, paint_width, paint_height, 1'b0};
    return x;
  endfunction

  task automatic drive(desc_t x);
    d.desc_sprite_x = x.sx;
    d.desc_sprite_y = x.sy;
    d.desc_frame_x  = x.fx;
    d.desc_frame_y  = x.fy;
    d.desc_width    = x.w;
    d.desc_height   = x.h;
    d.desc_last     = x.last;
  endtask

  task automatic push(desc_t x);
    drive(x);
    d.desc_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_33m);
      if (d.desc_ready) begin
        tick();
        d.desc_valid = 1'b0;
        model_q.push_back(x);
        return;
      end
      tick();
    end
    d.desc_valid = 1'b0;
    chk("push_timeout", 0, 1);
  endtask

  function automatic bit is_zero(desc_t x);
    return (x.w == '0) || (x.h == '0);
  endfunction

  task automatic run_frame(string tag);
    bit    prev_ps = 1'b1;
    bit    done = 1'b0;
    bit    last_painted = 1'b0;
    int    left = 0;
    desc_t prev_f = '0;
    desc_t cur_f;
    desc_t e;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < FW * FH; i++) begin
      @(negedge clk_33m);
      chk({tag, "_clr_act"}, clr_active, 1);
      chk({tag, "_clr_xy"}, {clr_y, clr_x}, {CW'(i / FW), CW'(i % FW)});
    end
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk_33m);
      cur_f = cur_fields();
      chk({tag, "_busy"}, busy, 1);
      if (clr_active) chk({tag, "_clr_late"}, clr_active, 0);
      if (prev_ps && !paint_start) begin
        e = '1;
        while (model_q.size() > 0) begin
          e = model_q.pop_front();
          if (!is_zero(e)) break;
        end
        last_painted = e.last;
        e.last = 1'b0;
        chk({tag, "_paint_desc"}, cur_f, e);
        chk({tag, "_start_stable"}, prev_f, e);
      end
      if (frame_done) begin
        done = 1'b1;
        if (last_painted)
          chk({tag, "_done_lat"}, cyc - fin_rise_cyc, 1);
        if (!last_painted) begin
          while (model_q.size() > 0) begin
            e = model_q.pop_front();
            if (!is_zero(e)) left++;
            if (e.last) break;
          end
        end
        chk({tag, "_unpainted"}, left, 0);
      end
      prev_ps = paint_start;
      prev_f  = cur_f;
    end
    if (!done) begin
      chk({tag, "_timeout"}, 0, 1);
    end else begin
      @(negedge clk_33m);
      chk({tag, "_done_pulse"}, frame_done, 0);
      chk({tag, "_idle_busy"}, busy, 0);
      chk({tag, "_idle_pstart"}, paint_start, 1);
    end
    tick();
  endtask

  initial begin
    desc_t x;
    desc_t x17;
    int    n;
    d.desc_valid = 1'b0;
    drive('0);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk_33m);
    chk("rst_pstart", paint_start, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_clr", clr_active, 0);
    chk("rst_ready", d.desc_ready, 1);
    chk("rst_width", paint_width, 0);
    tick();

    // Fill the FIFO, hold a 17th push off, then paint all of it.
    for (int i = 0; i < 16; i++) push(rdesc(1'b0, (i % 5) == 3));
    @(negedge clk_33m);
    chk("full_ready", d.desc_ready, 0);
    tick();
    x17 = rdesc(1'b1, 1'b0);
    drive(x17);
    d.desc_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_33m);
      chk("full_hold", d.desc_ready, 0);
      tick();
    end
    fork
      run_frame("fill");
      push(x17);
    join

    // Zero-width element followed by a 2x2 last element.
    x = rdesc(1'b0, 1'b0);
    x.w = '0;
    push(x);
    x = rdesc(1'b1, 1'b0);
    x.w = CW'(2);
    x.h = CW'(2);
    push(x);
    run_frame("skip");

    // Frame started on an empty FIFO.
    fork
      run_frame("stall");
      begin
        repeat (50) tick();
        push(rdesc(1'b1, 1'b0));
      end
    join

    for (int f = 0; f < 4; f++) begin
      n = int'($urandom_range(1, 6));
      for (int j = 0; j < n; j++)
        push(rdesc(j == n - 1, $urandom_range(0, 3) == 0));
      run_frame("rand");
    end

    // Reset in the middle of painting drops the frame and the FIFO.
    push(rdesc(1'b0, 1'b0));
    push(rdesc(1'b1, 1'b0));
    hang = 1'b1;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 100 && paint_start; i++) tick();
    chk("midrst_reach_paint", paint_start, 0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk_33m);
    chk("midrst_busy", busy, 0);
    chk("midrst_pstart", paint_start, 1);
    chk("midrst_done", frame_done, 0);
    chk("midrst_clr", clr_active, 0);
    chk("midrst_ready", d.desc_ready, 1);
    chk("midrst_width", paint_width, 0);
    hang = 1'b0;
    model_q.delete();
    tick();
    fork
      run_frame("postrst");
      begin
        repeat (40) tick();
        push(rdesc(1'b1, 1'b0));
      end
    join

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
